// File: rtl/rx_frame_parser.sv
// rx_frame_parser: hunts for SYNC, validates LEN/payload/checksum, buffers the payload
// and drains it through a ready/valid port; bad frames are dropped with a coded error pulse.
module rx_frame_parser #(
    parameter logic [7:0] SYNC    = 8'hA5,
    parameter int         MAX_LEN = 16,
    parameter int         TIMEOUT = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    input  logic       in_ok,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_last,
    output logic       pkt_err,
    output logic [1:0] err_code,
    output logic       drop,
    output logic       busy
);
    localparam int PW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [7:0]    MAX_B  = 8'(MAX_LEN);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

    localparam logic [2:0] HUNT    = 3'd0;
    localparam logic [2:0] LEN     = 3'd1;
    localparam logic [2:0] PAYLOAD = 3'd2;
    localparam logic [2:0] CHECK   = 3'd3;
    localparam logic [2:0] DRAIN   = 3'd4;

    logic [2:0]    state;
    logic [7:0]    buf_mem [0:(1<<PW)-1];
    logic [PW-1:0] cnt, lm1, rd_ptr;
    logic [7:0]    sum;
    logic [TW-1:0] tcnt;
    logic          active;

    assign active    = (state == LEN) || (state == PAYLOAD) || (state == CHECK);
    assign busy      = state != HUNT;
    assign out_valid = state == DRAIN;
    assign out_data  = out_valid ? buf_mem[rd_ptr] : 8'h00;
    assign out_last  = out_valid && (rd_ptr == lm1);
    assign drop      = out_valid && in_valid;

    // lm1 holds LEN-1 so both the fill and drain pointers compare against it directly
    always_ff @(posedge clk) begin
        pkt_err <= 1'b0;
        tcnt    <= (in_valid || !active) ? '0 : tcnt + 1'b1;
        if (!rst_n) begin
            state    <= HUNT;
            err_code <= 2'd0;
            tcnt     <= '0;
            cnt      <= '0;
            lm1      <= '0;
            rd_ptr   <= '0;
            sum      <= 8'd0;
        end else if (active && !in_valid && tcnt == T_LAST) begin
            pkt_err  <= 1'b1;
            err_code <= 2'd3;
            state    <= HUNT;
        end else begin
            case (state)
                HUNT: if (in_valid && in_ok && in_data == SYNC) state <= LEN;
                LEN: if (in_valid) begin
                    if (!in_ok || in_data == 8'd0 || in_data > MAX_B) begin
                        pkt_err  <= 1'b1;
                        err_code <= in_ok ? 2'd0 : 2'd1;
                        state    <= HUNT;
                    end else begin
                        lm1   <= PW'(in_data - 8'd1);
                        sum   <= in_data;
                        cnt   <= '0;
                        state <= PAYLOAD;
                    end
                end
                PAYLOAD: if (in_valid) begin
                    if (!in_ok) begin
                        pkt_err  <= 1'b1;
                        err_code <= 2'd1;
                        state    <= HUNT;
                    end else begin
                        buf_mem[cnt] <= in_data;
                        sum          <= sum + in_data;
                        cnt          <= cnt + 1'b1;
                        if (cnt == lm1) state <= CHECK;
                    end
                end
                CHECK: if (in_valid) begin
                    if (in_ok && in_data == sum) begin
                        rd_ptr <= '0;
                        state  <= DRAIN;
                    end else begin
                        pkt_err  <= 1'b1;
                        err_code <= in_ok ? 2'd2 : 2'd1;
                        state    <= HUNT;
                    end
                end
                DRAIN: if (out_ready) begin
                    rd_ptr <= rd_ptr + 1'b1;
                    if (rd_ptr == lm1) state <= HUNT;
                end
                default: state <= HUNT;
            endcase
        end
    end
endmodule

// File: tb/tb_rx_frame_parser.sv
// tb_rx_frame_parser: directed and randomized frames checked against a frame-level
// reference model that derives the expected outcome from the frame format rules.
module tb_rx_frame_parser;
    localparam int MAXL = 16;
    localparam int TOUT = 100;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] in_data = 8'd0;
    logic       in_valid = 1'b0;
    logic       in_ok = 1'b1;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic       out_last;
    logic       pkt_err;
    logic [1:0] err_code;
    logic       drop;
    logic       busy;

    int n_chk = 0;
    int n_fail = 0;
    logic [7:0] fb[$];
    bit         fo[$];

    rx_frame_parser #(.SYNC(8'hA5), .MAX_LEN(MAXL), .TIMEOUT(TOUT)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ok(in_ok),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
        .pkt_err(pkt_err), .err_code(err_code), .drop(drop), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_out_data"}, out_data, 0);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_last"}, out_last, 0);
        check({tag, "_pkt_err"}, pkt_err, 0);
        check({tag, "_err_code"}, err_code, 0);
        check({tag, "_drop"}, drop, 0);
        check({tag, "_busy"}, busy, 0);
    endtask

    task automatic send(input logic [7:0] b, input bit ok);
        in_data = b;
        in_valid = 1'b1;
        in_ok = ok;
        @(negedge clk);
        in_valid = 1'b0;
        in_ok = 1'b1;
        in_data = 8'd0;
    endtask

    task automatic all_ok();
        fo.delete();
        foreach (fb[i]) fo.push_back(1'b1);
    endtask

    // Expected outcome of the frame in fb/fo: index of the byte that kills it (-1 = accepted) and its code
    task automatic model(output int eidx, output int ecode);
        int len;
        logic [7:0] s;
        eidx = -1;
        ecode = 0;
        len = int'(fb[1]);
        if (!fo[1]) begin eidx = 1; ecode = 1; return; end
        if (len == 0 || len > MAXL) begin eidx = 1; ecode = 0; return; end
        s = fb[1];
        for (int i = 0; i < len; i++) begin
            if (!fo[2+i]) begin eidx = 2 + i; ecode = 1; return; end
            s += fb[2+i];
        end
        if (!fo[2+len]) begin eidx = 2 + len; ecode = 1; return; end
        if (fb[2+len] != s) begin eidx = 2 + len; ecode = 2; end
    endtask

    task automatic drain(input logic [31:0] rmask, input logic [31:0] vmask);
        int len, k, cyc;
        len = int'(fb[1]);
        k = 0;
        cyc = 0;
        while (k < len && cyc < 200) begin
            out_ready = (cyc < 32) ? rmask[cyc] : 1'b1;
            in_valid = (cyc < 32) ? vmask[cyc] : 1'b0;
            in_data = 8'($urandom);
            in_ok = 1'b1;
            #1;
            check("drain_valid", out_valid, 1);
            check("drain_data", out_data, fb[2+k]);
            check("drain_last", out_last, k == len - 1);
            check("drain_drop", drop, in_valid);
            check("drain_pkt_err", pkt_err, 0);
            @(posedge clk);
            if (out_ready) k++;
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        in_data = 8'd0;
        out_ready = 1'b1;
        check("drain_bound", cyc < 200, 1);
        check("post_drain_valid", out_valid, 0);
        check("post_drain_busy", busy, 0);
    endtask

    task automatic run_frame(input logic [31:0] rmask, input logic [31:0] vmask);
        int eidx, ecode;
        model(eidx, ecode);
        for (int i = 0; i < fb.size(); i++) begin
            send(fb[i], fo[i]);
            check("frame_pkt_err", pkt_err, i == eidx);
            check("frame_busy", busy, i != eidx);
            check("frame_out_valid", out_valid, eidx < 0 && i == fb.size() - 1);
            if (i == eidx) begin
                check("frame_err_code", err_code, ecode);
                break;
            end
        end
        if (eidx < 0) drain(rmask, vmask);
    endtask

    task automatic mk_frame(input int len, input int mode);
        logic [7:0] s;
        fb.delete();
        fb.push_back(8'hA5);
        fb.push_back(8'(len));
        s = 8'(len);
        if (len >= 1 && len <= MAXL) begin
            for (int i = 0; i < len; i++) begin
                fb.push_back(8'($urandom));
                s += fb[fb.size()-1];
            end
            fb.push_back(mode == 1 ? s + 8'($urandom_range(1, 255)) : s);
        end
        all_ok();
        if (mode == 2) fo[$urandom_range(1, fb.size() - 1)] = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;

        // Non-SYNC and bad SYNC bytes are ignored in HUNT
        send(8'h33, 1'b1);
        send(8'hA5, 1'b0);
        check("hunt_busy", busy, 0);
        check("hunt_pkt_err", pkt_err, 0);

        fb = {8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69};
        all_ok();
        run_frame(32'hFFFF_FFFF, 32'h0);

        fb = {8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h6A};
        all_ok();
        run_frame(32'hFFFF_FFFF, 32'h0);
        fb[5] = 8'h69;
        run_frame(32'hFFFF_FFFF, 32'h0);

        fb = {8'hA5, 8'h00};
        all_ok();
        run_frame(32'hFFFF_FFFF, 32'h0);
        fb = {8'hA5, 8'h11};
        all_ok();
        run_frame(32'hFFFF_FFFF, 32'h0);
        fb = {8'hA5, 8'h02, 8'h11};
        all_ok();
        fo[2] = 1'b0;
        run_frame(32'hFFFF_FFFF, 32'h0);

        // Stall for three cycles with a byte arriving mid-drain; SYNC inside payload is data
        fb = {8'hA5, 8'h04, 8'hA5, 8'h01, 8'hFF, 8'h10, 8'hB9};
        all_ok();
        run_frame(~32'b1110, 32'b100);

        mk_frame(MAXL, 0);
        run_frame(32'hFFFF_FFFF, 32'h0);
        mk_frame(1, 0);
        run_frame(32'hFFFF_FFFF, 32'h0);

        // Silence after a partial frame times out exactly TOUT cycles after the last byte
        send(8'hA5, 1'b1);
        send(8'h02, 1'b1);
        send(8'h11, 1'b1);
        for (int n = 1; n <= TOUT; n++) begin
            @(negedge clk);
            check("timeout_pkt_err", pkt_err, n == TOUT);
        end
        check("timeout_code", err_code, 3);
        check("timeout_busy", busy, 0);

        fb = {8'hA5, 8'h02, 8'h11, 8'h22, 8'h35};
        all_ok();
        send(fb[0], 1'b1);
        send(fb[1], 1'b1);
        send(fb[2], 1'b1);
        repeat (TOUT - 1) @(negedge clk);
        check("late_byte_busy", busy, 1);
        send(fb[3], 1'b1);
        check("late_byte_pkt_err", pkt_err, 0);
        check("late_byte_busy2", busy, 1);
        send(fb[4], 1'b1);
        check("late_chk_valid", out_valid, 1);
        drain(32'hFFFF_FFFF, 32'h0);

        // Reset mid-PAYLOAD
        send(8'hA5, 1'b1);
        send(8'h03, 1'b1);
        send(8'h11, 1'b1);
        rst_n = 1'b0;
        @(negedge clk);
        check_zero("rst_payload");
        rst_n = 1'b1;
        mk_frame(5, 0);
        run_frame(32'hFFFF_FFFF, 32'h0);

        // Reset mid-DRAIN
        mk_frame(3, 0);
        out_ready = 1'b0;
        foreach (fb[i]) send(fb[i], 1'b1);
        @(negedge clk);
        check("pre_rst_valid", out_valid, 1);
        check("pre_rst_data", out_data, fb[2]);
        rst_n = 1'b0;
        @(negedge clk);
        check_zero("rst_drain");
        rst_n = 1'b1;
        out_ready = 1'b1;
        mk_frame(4, 0);
        run_frame(32'hFFFF_FFFF, 32'h0);

        for (int f = 0; f < 40; f++) begin
            mk_frame($urandom_range(0, MAXL + 2), $urandom_range(0, 3));
            run_frame($urandom | 32'h1, $urandom & $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
